// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl
// Sequencing controller for the board combination lock. It turns debounced
// button pulses into inc/dec/clear commands for the shared up/down digit
// counter. It captures the counter value as each digit is confirmed and
// compares the full entry against the stored code. It also runs the
// unlock / fail / lockout state machine.
//
// Ports
//   clk, rst      board clock, asynchronous active-high reset
//   btn_up/dn     single-cycle pulses: increment / decrement current digit
//   btn_next      single-cycle pulse: confirm digit, or load new code in OPEN
//   btn_clr       single-cycle pulse: abort entry, or relock in OPEN
//   prog_en       switch level enabling code reprogramming while OPEN
//   code_in       new code from switches, digit 0 in the LSBs
//   cnt_val       current value of the external up/down counter
//   cnt_inc/dec/clr  registered one-cycle commands to the counter
//   digit_idx     index of the digit being entered
//   state_o       ENTRY=0, CHECK=1, OPEN=2, FAIL=3, LOCKOUT=4
//   unlocked      high in OPEN
//   alarm         high in LOCKOUT
//   fail_cnt      consecutive failed attempts
module combo_lock_ctrl #(
    parameter int                     DIGITS         = 4,
    parameter int                     DW             = 4,
    parameter logic [DIGITS*DW-1:0]   RESET_CODE     = '0,
    parameter int                     FAIL_CYCLES    = 50_000_000,
    parameter int                     LOCKOUT_CYCLES = 500_000_000,
    parameter int                     MAX_FAILS      = 3,
    localparam int                    IW             = $clog2(DIGITS),
    localparam int                    FW             = $clog2(MAX_FAILS + 1),
    localparam int                    CW             = DIGITS * DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_up,
    input  logic          btn_dn,
    input  logic          btn_next,
    input  logic          btn_clr,
    input  logic          prog_en,
    input  logic [CW-1:0] code_in,
    input  logic [DW-1:0] cnt_val,
    output logic          cnt_inc,
    output logic          cnt_dec,
    output logic          cnt_clr,
    output logic [IW-1:0] digit_idx,
    output logic [2:0]    state_o,
    output logic          unlocked,
    output logic          alarm,
    output logic [FW-1:0] fail_cnt
);

    localparam logic [2:0] S_ENTRY   = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;

    localparam int TMAX = (FAIL_CYCLES > LOCKOUT_CYCLES) ? FAIL_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // The timer is loaded with N-1 and the exit happens on the cycle it reads
    // zero, so the FAIL/LOCKOUT state is visible for exactly N clocks.
    localparam logic [TW-1:0] FAIL_LOAD    = TW'(FAIL_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] MAX_FAILS_V  = FW'(MAX_FAILS);
    localparam logic [IW-1:0] LAST_IDX     = IW'(DIGITS - 1);

    logic [2:0]    state_q,     state_d;
    logic [IW-1:0] digit_idx_q, digit_idx_d;
    logic [CW-1:0] entry_q,     entry_d;
    logic [CW-1:0] code_q,      code_d;
    logic [FW-1:0] fail_cnt_q,  fail_cnt_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic          cnt_inc_q,   cnt_inc_d;
    logic          cnt_dec_q,   cnt_dec_d;
    logic          cnt_clr_q,   cnt_clr_d;
    logic          unlocked_q,  unlocked_d;
    logic          alarm_q,     alarm_d;
    logic [FW-1:0] fail_next;

    always_comb begin
        state_d     = state_q;
        digit_idx_d = digit_idx_q;
        entry_d     = entry_q;
        code_d      = code_q;
        fail_cnt_d  = fail_cnt_q;
        timer_d     = timer_q;
        cnt_inc_d   = 1'b0;
        cnt_dec_d   = 1'b0;
        cnt_clr_d   = 1'b0;
        fail_next   = fail_cnt_q + FW'(1);

        case (state_q)
            S_ENTRY: begin
                if (btn_clr) begin
                    entry_d     = '0;
                    digit_idx_d = '0;
                    cnt_clr_d   = 1'b1;
                end else if (btn_next) begin
                    entry_d[int'(digit_idx_q)*DW +: DW] = cnt_val;
                    cnt_clr_d = 1'b1;
                    if (digit_idx_q == LAST_IDX) begin
                        state_d = S_CHECK;
                    end else begin
                        digit_idx_d = digit_idx_q + IW'(1);
                    end
                end else if (btn_up ^ btn_dn) begin
                    // Simultaneous up and down cancel out.
                    cnt_inc_d = btn_up;
                    cnt_dec_d = btn_dn;
                end
            end

            S_CHECK: begin
                digit_idx_d = '0;
                if (entry_q == code_q) begin
                    state_d    = S_OPEN;
                    fail_cnt_d = '0;
                end else begin
                    fail_cnt_d = fail_next;
                    if (fail_next == MAX_FAILS_V) begin
                        state_d = S_LOCKOUT;
                        timer_d = LOCKOUT_LOAD;
                    end else begin
                        state_d = S_FAIL;
                        timer_d = FAIL_LOAD;
                    end
                end
            end

            S_FAIL: begin
                if (timer_q == '0) begin
                    entry_d   = '0;
                    cnt_clr_d = 1'b1;
                    state_d   = S_ENTRY;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_cnt_d = '0;
                    entry_d    = '0;
                    cnt_clr_d  = 1'b1;
                    state_d    = S_ENTRY;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            S_OPEN: begin
                // Relock has priority over reprogramming.
                if (btn_clr) begin
                    entry_d   = '0;
                    cnt_clr_d = 1'b1;
                    state_d   = S_ENTRY;
                end else if (btn_next && prog_en) begin
                    code_d = code_in;
                end
            end

            default: begin
                state_d     = S_ENTRY;
                digit_idx_d = '0;
                entry_d     = '0;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with state_o.
        unlocked_d = (state_d == S_OPEN);
        alarm_d    = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ENTRY;
            digit_idx_q <= '0;
            entry_q     <= '0;
            code_q      <= RESET_CODE;
            fail_cnt_q  <= '0;
            timer_q     <= '0;
            cnt_inc_q   <= 1'b0;
            cnt_dec_q   <= 1'b0;
            cnt_clr_q   <= 1'b0;
            unlocked_q  <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_idx_q <= digit_idx_d;
            entry_q     <= entry_d;
            code_q      <= code_d;
            fail_cnt_q  <= fail_cnt_d;
            timer_q     <= timer_d;
            cnt_inc_q   <= cnt_inc_d;
            cnt_dec_q   <= cnt_dec_d;
            cnt_clr_q   <= cnt_clr_d;
            unlocked_q  <= unlocked_d;
            alarm_q     <= alarm_d;
        end
    end

    assign cnt_inc   = cnt_inc_q;
    assign cnt_dec   = cnt_dec_q;
    assign cnt_clr   = cnt_clr_q;
    assign digit_idx = digit_idx_q;
    assign state_o   = state_q;
    assign unlocked  = unlocked_q;
    assign alarm     = alarm_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed testbench for combo_lock_ctrl with RESET_CODE=16'h1234,
// FAIL_CYCLES=4, LOCKOUT_CYCLES=8, MAX_FAILS=3.
module tb_combo_lock_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_dn = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_clr = 1'b0;
    logic        prog_en = 1'b0;
    logic [15:0] code_in = 16'h0000;
    logic [3:0]  cnt_val = 4'h0;
    logic        cnt_inc, cnt_dec, cnt_clr;
    logic [1:0]  digit_idx;
    logic [2:0]  state_o;
    logic        unlocked, alarm;
    logic [1:0]  fail_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    combo_lock_ctrl #(
        .DIGITS(4), .DW(4), .RESET_CODE(16'h1234),
        .FAIL_CYCLES(4), .LOCKOUT_CYCLES(8), .MAX_FAILS(3)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_dn(btn_dn), .btn_next(btn_next), .btn_clr(btn_clr),
        .prog_en(prog_en), .code_in(code_in), .cnt_val(cnt_val),
        .cnt_inc(cnt_inc), .cnt_dec(cnt_dec), .cnt_clr(cnt_clr),
        .digit_idx(digit_idx), .state_o(state_o),
        .unlocked(unlocked), .alarm(alarm), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enters four digits, digit 0 first; ends with the DUT in CHECK.
    task automatic enter4(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            cnt_val  = c[i*4 +: 4];
            btn_next = 1'b1;
            tick();
            btn_next = 1'b0;
            chk("next_clr", cnt_clr, 1);
            if (i < 3) begin
                chk("next_idx", digit_idx, i + 1);
                tick();
                chk("clr_width", cnt_clr, 0);
                tick();
            end else begin
                chk("to_check", state_o, 1);
            end
        end
    endtask

    task automatic expect_open();
        tick();
        chk("open_state", state_o, 2);
        chk("open_unlocked", unlocked, 1);
        chk("open_fail_cnt", fail_cnt, 0);
        chk("open_idx", digit_idx, 0);
        idle(2);
    endtask

    task automatic relock();
        btn_clr = 1'b1;
        tick();
        btn_clr = 1'b0;
        chk("relock_state", state_o, 0);
        chk("relock_unlocked", unlocked, 0);
        chk("relock_clr", cnt_clr, 1);
        idle(2);
    endtask

    // From CHECK with a wrong entry: FAIL visible 4 cycles, then ENTRY.
    task automatic fail_round(input int exp_cnt);
        tick();
        chk("fail_state1", state_o, 3);
        chk("fail_cnt", fail_cnt, exp_cnt);
        chk("fail_unlocked", unlocked, 0);
        chk("fail_idx", digit_idx, 0);
        btn_up = 1'b1;
        tick();
        btn_up = 1'b0;
        chk("fail_state2", state_o, 3);
        chk("fail_no_inc", cnt_inc, 0);
        tick();
        chk("fail_state3", state_o, 3);
        tick();
        chk("fail_state4", state_o, 3);
        tick();
        chk("fail_exit_state", state_o, 0);
        chk("fail_exit_clr", cnt_clr, 1);
        chk("fail_exit_cnt", fail_cnt, exp_cnt);
        idle(2);
    endtask

    initial begin
        // Reset state
        idle(2);
        chk("rst_state", state_o, 0);
        chk("rst_idx", digit_idx, 0);
        chk("rst_cmds", {cnt_inc, cnt_dec, cnt_clr}, 0);
        chk("rst_flags", {unlocked, alarm}, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        rst = 1'b0;
        idle(2);

        // Three increments
        for (int i = 0; i < 3; i++) begin
            btn_up = 1'b1;
            tick();
            btn_up = 1'b0;
            chk("up_inc", cnt_inc, 1);
            chk("up_dec", cnt_dec, 0);
            chk("up_clr", cnt_clr, 0);
            tick();
            chk("up_inc_width", cnt_inc, 0);
            tick();
        end

        // Correct code unlocks, then relock
        enter4(16'h1234);
        expect_open();
        relock();

        // Three failures lead to lockout
        enter4(16'h0234);
        fail_round(1);
        enter4(16'h0234);
        fail_round(2);
        enter4(16'h0234);
        tick();
        chk("lock_state1", state_o, 4);
        chk("lock_alarm1", alarm, 1);
        chk("lock_fail_cnt", fail_cnt, 3);
        for (int i = 1; i < 8; i++) begin
            btn_clr = (i == 2);
            btn_dn  = (i == 5);
            tick();
            btn_clr = 1'b0;
            btn_dn  = 1'b0;
            chk("lock_state", state_o, 4);
            chk("lock_alarm", alarm, 1);
            chk("lock_no_cmd", {cnt_clr, cnt_dec}, 0);
        end
        tick();
        chk("lock_exit_state", state_o, 0);
        chk("lock_exit_alarm", alarm, 0);
        chk("lock_exit_fail_cnt", fail_cnt, 0);
        chk("lock_exit_clr", cnt_clr, 1);
        idle(2);

        // Reprogram to 5678 while open
        enter4(16'h1234);
        expect_open();
        prog_en  = 1'b1;
        code_in  = 16'h5678;
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        prog_en  = 1'b0;
        chk("prog_state", state_o, 2);
        chk("prog_no_clr", cnt_clr, 0);
        idle(2);
        relock();
        enter4(16'h5678);
        expect_open();
        relock();
        enter4(16'h1234);
        fail_round(1);

        // Up and down together: no command; down alone: dec
        btn_up = 1'b1;
        btn_dn = 1'b1;
        tick();
        btn_up = 1'b0;
        btn_dn = 1'b0;
        chk("updn_none", {cnt_inc, cnt_dec}, 0);
        idle(2);
        btn_dn = 1'b1;
        tick();
        btn_dn = 1'b0;
        chk("dn_dec", cnt_dec, 1);
        chk("dn_inc", cnt_inc, 0);
        idle(2);

        // Clear after two digits
        cnt_val  = 4'h5;
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        idle(2);
        cnt_val  = 4'h6;
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        chk("two_idx", digit_idx, 2);
        idle(2);
        btn_clr = 1'b1;
        tick();
        btn_clr = 1'b0;
        chk("clr_idx", digit_idx, 0);
        chk("clr_pulse", cnt_clr, 1);
        idle(2);

        // Clear and next together in ENTRY: clear wins
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        chk("one_idx", digit_idx, 1);
        idle(2);
        btn_clr  = 1'b1;
        btn_next = 1'b1;
        tick();
        btn_clr  = 1'b0;
        btn_next = 1'b0;
        chk("clrnext_idx", digit_idx, 0);
        chk("clrnext_clr", cnt_clr, 1);
        chk("clrnext_state", state_o, 0);
        idle(2);

        // Clear and next together in OPEN: relock, code unchanged
        enter4(16'h5678);
        expect_open();
        prog_en  = 1'b1;
        code_in  = 16'h9999;
        btn_clr  = 1'b1;
        btn_next = 1'b1;
        tick();
        btn_clr  = 1'b0;
        btn_next = 1'b0;
        prog_en  = 1'b0;
        chk("open_clrnext_state", state_o, 0);
        chk("open_clrnext_clr", cnt_clr, 1);
        idle(2);
        enter4(16'h5678);
        expect_open();
        relock();

        // Reset in the middle of lockout
        enter4(16'h0000);
        fail_round(1);
        enter4(16'h0000);
        fail_round(2);
        enter4(16'h0000);
        tick();
        chk("rl_lock", state_o, 4);
        idle(2);
        rst = 1'b1;
        #1;
        chk("rl_state", state_o, 0);
        chk("rl_alarm", alarm, 0);
        chk("rl_fail_cnt", fail_cnt, 0);
        chk("rl_cmds", {cnt_inc, cnt_dec, cnt_clr}, 0);
        btn_up = 1'b1;
        tick();
        btn_up = 1'b0;
        chk("rl_no_inc", cnt_inc, 0);
        tick();
        chk("rl_quiet", {cnt_inc, cnt_dec, cnt_clr, unlocked, alarm}, 0);
        rst = 1'b0;
        idle(2);
        enter4(16'h1234);
        expect_open();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/combo_lock_ctrl.md
Name: combo_lock_ctrl

Overview:
Sequencing controller for the combination lock on the Basys board. It turns debounced button pulses into inc/dec/clear commands for the shared up/down digit counter. It captures the counter value as each code digit is confirmed, compares the full entry against a stored code, and runs the unlock / fail / lockout state machine. Its outputs drive the LED array and the seven-segment digit select in the board-level top.

Parameters:
DIGITS, 4, number of code digits (2..8)
DW, 4, bits per digit; must match the up/down counter width
RESET_CODE, 16'h0000, code loaded at reset, DIGITS*DW bits; digit 0 in LSBs
FAIL_CYCLES, 50_000_000, clocks the FAIL indication is held
LOCKOUT_CYCLES, 500_000_000, clocks the alarm lockout is held
MAX_FAILS, 3, consecutive failed attempts that trigger lockout (>=1)

Ports:
clk  in  1  board clock
rst  in  1  asynchronous, active-high reset
btn_up  in  1  single-cycle pulse: increment current digit
btn_dn  in  1  single-cycle pulse: decrement current digit
btn_next  in  1  single-cycle pulse: confirm digit / load new code
btn_clr  in  1  single-cycle pulse: abort entry / relock
prog_en  in  1  level from a switch; enables code reprogramming while open
code_in  in  DIGITS*DW  new code from switches; digit 0 in LSBs
cnt_val  in  DW  current value of the up/down counter
cnt_inc  out  1  one-cycle increment command to the counter
cnt_dec  out  1  one-cycle decrement command to the counter
cnt_clr  out  1  one-cycle clear command to the counter
digit_idx  out  clog2(DIGITS)  index of the digit being entered
state_o  out  3  encoded state: ENTRY=0, CHECK=1, OPEN=2, FAIL=3, LOCKOUT=4
unlocked  out  1  high in OPEN
alarm  out  1  high in LOCKOUT
fail_cnt  out  clog2(MAX_FAILS+1)  consecutive failure count

Behaviour:
- Reset (async, takes effect immediately): state ENTRY; digit_idx=0; cnt_inc, cnt_dec, cnt_clr, unlocked, alarm = 0; fail_cnt=0; entry register=0; code register=RESET_CODE; timer=0. Reset asserted mid-operation aborts any state with no residual pulses.
- All outputs are registered. Command pulses appear 1 cycle after the triggering button pulse and last exactly 1 cycle.
- Upstream guarantee: button pulses are at least 3 cycles apart. cnt_val is sampled in the same cycle btn_next is seen.
- ENTRY state, one action per cycle, priority btn_clr > btn_next > btn_up/btn_dn:
  - btn_clr: entry=0, digit_idx=0, cnt_clr pulse.
  - btn_next: entry[digit_idx]=cnt_val and cnt_clr pulse. If digit_idx==DIGITS-1, go to CHECK; otherwise digit_idx+1.
  - btn_up only: cnt_inc pulse. btn_dn only: cnt_dec pulse. Both in the same cycle: no command.
- CHECK lasts 1 cycle and ignores buttons. digit_idx is set to 0.
  - entry==code: go to OPEN, fail_cnt=0.
  - Otherwise fail_cnt+1. If the new count == MAX_FAILS, go to LOCKOUT; else go to FAIL. Either way, load the timer.
- FAIL: buttons ignored; timer counts down FAIL_CYCLES clocks. At expiry: entry=0, cnt_clr pulse, go to ENTRY.
- LOCKOUT: alarm=1; buttons ignored; timer counts down LOCKOUT_CYCLES clocks. At expiry: fail_cnt=0, entry=0, cnt_clr pulse, go to ENTRY.
- OPEN: unlocked=1.
  - btn_clr: relock. entry=0, cnt_clr pulse, go to ENTRY, unlocked=0 on the next cycle.
  - btn_next with prog_en=1: code register=code_in; stay in OPEN.
  - btn_next with prog_en=0, btn_up, btn_dn: ignored.
  - Same-cycle btn_clr and btn_next: clr wins and the code is not loaded.
- Timer is sized for max(FAIL_CYCLES, LOCKOUT_CYCLES). The state-exit cycle is exactly the terminal count; there is no off-by-one wrap.
- The code register changes only at reset or through the OPEN programming path.

Test Plan:
All tests use RESET_CODE=16'h1234, FAIL_CYCLES=4, LOCKOUT_CYCLES=8, MAX_FAILS=3.
- Reset then btn_up ×3 -> three cnt_inc pulses, each 1 cycle after its button; cnt_dec and cnt_clr stay 0.
- Enter digits 4,3,2,1 (cnt_val driven to each value, then btn_next) -> four cnt_clr pulses; digit_idx goes 0→1→2→3; CHECK for 1 cycle; then OPEN with unlocked=1 and fail_cnt=0.
- Enter 4,3,2,0 three times -> fail_cnt goes 1, then 2 (FAIL held 4 cycles each time), then 3 → LOCKOUT with alarm=1 for 8 cycles; then ENTRY with fail_cnt=0. Buttons pressed during FAIL or LOCKOUT produce no commands.
- While OPEN: prog_en=1, code_in=16'h5678, btn_next; then btn_clr -> ENTRY. Entering 8,7,6,5 unlocks; entering 4,3,2,1 now fails.
- btn_up and btn_dn in the same cycle -> no command. btn_clr after two digits -> digit_idx=0 and cnt_clr pulses. btn_clr and btn_next in the same cycle -> clr wins.
- Assert rst during LOCKOUT mid-count -> alarm=0, state ENTRY, code back to 16'h1234, and no pulses for the rest of the reset.
